// File: rtl/fir_mac_sequencer.sv
// Serial FIR controller: one multiplier and one accumulator shared across N taps.
// Samples arrive over a valid/ready handshake into a circular history buffer,
// one multiply-accumulate runs per tap, and each result is returned over a
// valid/ready handshake. Coefficients and the history clear are accepted in IDLE only.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready high; accept sample, coefficient writes, history clear
// MAC   | one tap per cycle, k = 0..N-1, newest sample weighted by coef[0]
// DONE  | out_valid high, out_data held until out_ready
module fir_mac_sequencer #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        out_data,
  input  logic                 coef_we,
  input  logic [$clog2(N)-1:0] coef_addr,
  input  logic [CW-1:0]        coef_wdata,
  input  logic                 hist_clr,
  output logic                 busy
);

  localparam int AW = $clog2(N);
  localparam int PW = DW + CW;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0] samp_q [N];
  logic [CW-1:0] coef_q [N];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] k_q;
  logic [OW-1:0] acc_q;
  logic [OW-1:0] out_q;

  logic          accept;
  logic          mac_step;
  logic          mac_last;
  logic          coef_wr;
  logic          clr;
  logic [AW-1:0] tap_idx;
  logic [AW-1:0] wp_next;
  logic [PW-1:0] prod;
  logic [OW-1:0] acc_sum;

  // State register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mac_step = 1'b0;
    mac_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        mac_step = 1'b1;
        if (k_q == LAST) begin
          mac_last = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = ~in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_q;

  assign coef_wr = in_ready & coef_we & (int'(coef_addr) < N);
  assign clr     = in_ready & hist_clr;

  // History index for tap k: (base - k) mod N, valid for any N, not just powers of two.
  always_comb begin
    tap_idx = '0;
    if (base_q >= k_q) begin
      tap_idx = base_q - k_q;
    end else begin
      tap_idx = AW'(N + int'(base_q) - int'(k_q));
    end
  end

  assign wp_next = (base_q == LAST) ? '0 : base_q + AW'(1);
  assign prod    = PW'(samp_q[tap_idx]) * PW'(coef_q[k_q]);
  assign acc_sum = acc_q + OW'(prod);

  // Sample history: clear first, so a same-edge sample lands in slot 0.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int j = 0; j < N; j++) begin
        samp_q[j] <= '0;
      end
    end else begin
      if (clr) begin
        for (int j = 0; j < N; j++) begin
          samp_q[j] <= '0;
        end
      end
      if (accept) begin
        samp_q[clr ? '0 : wp_q] <= in_data;
      end
    end
  end

  // Coefficient bank, reset to a ramp 2, 4, 6, ... so the block filters out of reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int j = 0; j < N; j++) begin
        coef_q[j] <= CW'(2 * (j + 1));
      end
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  // Write pointer advances once per sample, when the MAC pass completes.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wp_q <= '0;
    end else if (clr) begin
      wp_q <= '0;
    end else if (mac_last) begin
      wp_q <= wp_next;
    end
  end

  // Base latch, tap counter and accumulator for the MAC pass.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      base_q <= '0;
      k_q    <= '0;
      acc_q  <= '0;
    end else if (accept) begin
      base_q <= clr ? '0 : wp_q;
      k_q    <= '0;
      acc_q  <= '0;
    end else if (mac_step) begin
      k_q   <= mac_last ? '0 : k_q + AW'(1);
      acc_q <= acc_sum;
    end
  end

  // Result register: loads only on the MAC-to-DONE edge so out_data stays stable otherwise.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_q <= '0;
    end else if (mac_last) begin
      out_q <= acc_sum;
    end
  end

endmodule
